// File: rtl/gpu_definitions.sv
// Shared definitions for the GPU background path.
// Holds the VRAM region bases, LCDC bit positions, the background line FSM
// state codes and the VRAM address helpers used by the line renderer.
package gpu_definitions;

  // VRAM region bases
  localparam logic [15:0] TileBase8000 = 16'h8000;
  // Signed tile addressing is centred on 0x9000, covering 0x8800..0x97FF.
  localparam logic [15:0] TileBase9000 = 16'h9000;
  localparam logic [15:0] MapBase9800  = 16'h9800;
  localparam logic [15:0] MapBase9C00  = 16'h9C00;

  // LCDC bit indices
  localparam int unsigned LcdcBgEnable   = 0;
  localparam int unsigned LcdcMapSelect  = 3;
  localparam int unsigned LcdcTileSelect = 4;

  // Background line FSM states
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StMapRd = 3'd1;
  localparam logic [2:0] StLoRd  = 3'd2;
  localparam logic [2:0] StHiRd  = 3'd3;
  localparam logic [2:0] StShift = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  // Tile-map byte address; the horizontal tile index wraps within the 32-tile row.
  function automatic logic [15:0] bg_map_addr(input logic [7:0] y,
                                              input logic [4:0] scx_coarse,
                                              input logic       map_sel,
                                              input logic [4:0] col);
    logic [4:0] x;
    x = scx_coarse + col;
    return (map_sel ? MapBase9C00 : MapBase9800) + {6'b0, y[7:3], x};
  endfunction

  // Low-plane byte address of a tile row; high plane is the next byte.
  function automatic logic [15:0] bg_tile_lo_addr(input logic [7:0] idx,
                                                  input logic [2:0] row,
                                                  input logic       unsigned_mode);
    logic [15:0] offset;
    offset = unsigned_mode ? {4'b0, idx, 4'b0} : {{4{idx[7]}}, idx, 4'b0};
    return (unsigned_mode ? TileBase8000 : TileBase9000) + offset + {12'b0, row, 1'b0};
  endfunction

endpackage

// File: rtl/gpu_bg_pixel_shifter.sv
// Background pixel shifter and frame-buffer packer.
// Holds one tile row (lo/hi planes), maps the MSB pixel through BGP and packs
// emitted pixels into PIXELS_PER_WORD-pixel words, leftmost pixel in the MSBs.
// Ports: clk/reset (sync, active-high); clear resets packing for a new line;
// load/lo_plane/hi_plane load a tile row; shift advances the planes; emit
// pushes the current pixel (forced to 0 when zero_fill); base_addr is the
// line's first word address; fb_we/fb_addr/fb_data are the registered writes.
module gpu_bg_pixel_shifter #(
  parameter int unsigned PIXELS_PER_WORD = 8,
  parameter int unsigned FB_ADDR_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         load,
  input  logic [7:0]                   lo_plane,
  input  logic [7:0]                   hi_plane,
  input  logic                         shift,
  input  logic                         emit,
  input  logic                         zero_fill,
  input  logic [7:0]                   bgp,
  input  logic [FB_ADDR_WIDTH-1:0]     base_addr,
  output logic                         fb_we,
  output logic [FB_ADDR_WIDTH-1:0]     fb_addr,
  output logic [2*PIXELS_PER_WORD-1:0] fb_data
);

  localparam int unsigned DataW = 2 * PIXELS_PER_WORD;

  logic [7:0]               lo_q, hi_q;
  logic [DataW-1:0]         acc_q;
  logic [3:0]               cnt_q;
  logic [FB_ADDR_WIDTH-1:0] word_idx_q;
  logic [1:0]               colour;
  logic [1:0]               pixel;
  logic [DataW-1:0]         acc_next;
  logic                     word_full;

  assign colour = {hi_q[7], lo_q[7]};

  always_comb begin
    pixel = 2'b00;
    if (!zero_fill) begin
      case (colour)
        2'd0:    pixel = bgp[1:0];
        2'd1:    pixel = bgp[3:2];
        2'd2:    pixel = bgp[5:4];
        default: pixel = bgp[7:6];
      endcase
    end
  end

  assign acc_next  = DataW'({acc_q, pixel});
  assign word_full = (cnt_q == 4'(PIXELS_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      lo_q       <= '0;
      hi_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      word_idx_q <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
    end else begin
      fb_we <= 1'b0;
      if (load) begin
        lo_q <= lo_plane;
        hi_q <= hi_plane;
      end else if (shift) begin
        lo_q <= {lo_q[6:0], 1'b0};
        hi_q <= {hi_q[6:0], 1'b0};
      end
      if (clear) begin
        acc_q      <= '0;
        cnt_q      <= '0;
        word_idx_q <= '0;
      end else if (emit) begin
        if (word_full) begin
          fb_we      <= 1'b1;
          fb_data    <= acc_next;
          fb_addr    <= base_addr + word_idx_q;
          word_idx_q <= word_idx_q + 1'b1;
          cnt_q      <= '0;
          acc_q      <= '0;
        end else begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/gpu_bg_line_renderer.sv
// Hardwired background scanline renderer.
// On iStart, latches LY/LCDC/SCX/SCY/BGP, fetches map and tile bytes through
// the MCU read port (request held until valid), applies scroll and palette and
// writes packed 2-bit pixels to the frame buffer. oBusy covers the line,
// oDone pulses one cycle after the last write. With LCDC[0]=0 the line is
// zero-filled without any VRAM reads.
module gpu_bg_line_renderer
  import gpu_definitions::*;
#(
  parameter int unsigned PIXELS_PER_WORD = 8,
  parameter int unsigned LINE_PIXELS     = 160,
  parameter int unsigned FB_ADDR_WIDTH   = 16
) (
  input  logic                         iClock,
  input  logic                         iReset,
  input  logic                         iStart,
  input  logic [7:0]                   iLine,
  input  logic [7:0]                   iLCDC,
  input  logic [7:0]                   iSCX,
  input  logic [7:0]                   iSCY,
  input  logic [7:0]                   iBGP,
  output logic [15:0]                  oMcuAddr,
  output logic                         oMcuReadRequest,
  input  logic [7:0]                   iMcuReadData,
  input  logic                         iMcuReadValid,
  output logic                         oFramBufferWe,
  output logic [FB_ADDR_WIDTH-1:0]     oFramBufferAddr,
  output logic [2*PIXELS_PER_WORD-1:0] oFramBufferData,
  output logic                         oBusy,
  output logic                         oDone
);

  localparam int unsigned PixW         = $clog2(LINE_PIXELS);
  localparam int unsigned WordsPerLine = LINE_PIXELS / PIXELS_PER_WORD;
  localparam logic [PixW-1:0] LastPix  = PixW'(LINE_PIXELS - 1);

  logic [2:0]      state_q, state_d;
  logic [7:0]      line_q, line_d, scy_q, scy_d, bgp_q, bgp_d, lo_q, lo_d;
  logic [4:0]      scx_coarse_q, scx_coarse_d, col_q, col_d;
  logic            map_sel_q, map_sel_d, tile_sel_q, tile_sel_d;
  logic            zero_fill_q, zero_fill_d;
  logic [2:0]      shift_cnt_q, shift_cnt_d, discard_q, discard_d;
  logic [PixW-1:0] pix_cnt_q, pix_cnt_d;
  logic [15:0]     addr_q, addr_d;
  logic            req_q, req_d, busy_q, busy_d, done_q, done_d;
  logic            sh_clear, sh_load, sh_shift, sh_emit;
  logic [7:0]      y_start, y_cur;
  logic [FB_ADDR_WIDTH-1:0] fb_base;

  logic unused_lcdc;
  assign unused_lcdc = ^{iLCDC[7:5], iLCDC[2:1]};

  assign y_start = iLine + iSCY;
  assign y_cur   = line_q + scy_q;
  assign fb_base = FB_ADDR_WIDTH'(32'(line_q) * WordsPerLine);

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    scy_d        = scy_q;
    bgp_d        = bgp_q;
    lo_d         = lo_q;
    scx_coarse_d = scx_coarse_q;
    col_d        = col_q;
    map_sel_d    = map_sel_q;
    tile_sel_d   = tile_sel_q;
    zero_fill_d  = zero_fill_q;
    shift_cnt_d  = shift_cnt_q;
    discard_d    = discard_q;
    pix_cnt_d    = pix_cnt_q;
    addr_d       = addr_q;
    req_d        = req_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    sh_clear     = 1'b0;
    sh_load      = 1'b0;
    sh_shift     = 1'b0;
    sh_emit      = 1'b0;
    case (state_q)
      StIdle: begin
        if (iStart) begin
          line_d       = iLine;
          scy_d        = iSCY;
          bgp_d        = iBGP;
          scx_coarse_d = iSCX[7:3];
          map_sel_d    = iLCDC[LcdcMapSelect];
          tile_sel_d   = iLCDC[LcdcTileSelect];
          zero_fill_d  = !iLCDC[LcdcBgEnable];
          col_d        = '0;
          pix_cnt_d    = '0;
          shift_cnt_d  = '0;
          busy_d       = 1'b1;
          sh_clear     = 1'b1;
          if (iLCDC[LcdcBgEnable]) begin
            discard_d = iSCX[2:0];
            req_d     = 1'b1;
            addr_d    = bg_map_addr(y_start, iSCX[7:3], iLCDC[LcdcMapSelect], 5'd0);
            state_d   = StMapRd;
          end else begin
            discard_d = '0;
            state_d   = StShift;
          end
        end
      end
      StMapRd: begin
        if (iMcuReadValid) begin
          addr_d  = bg_tile_lo_addr(iMcuReadData, y_cur[2:0], tile_sel_q);
          state_d = StLoRd;
        end
      end
      StLoRd: begin
        if (iMcuReadValid) begin
          lo_d    = iMcuReadData;
          addr_d  = addr_q + 16'd1;
          state_d = StHiRd;
        end
      end
      StHiRd: begin
        if (iMcuReadValid) begin
          sh_load = 1'b1;
          req_d   = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        sh_shift    = 1'b1;
        shift_cnt_d = shift_cnt_q + 3'd1;
        // Fine-X discard only ever applies to the first tile.
        if (discard_q != 3'd0) begin
          discard_d = discard_q - 3'd1;
        end else begin
          sh_emit   = 1'b1;
          pix_cnt_d = pix_cnt_q + PixW'(1);
        end
        if ((discard_q == 3'd0) && (pix_cnt_q == LastPix)) begin
          state_d = StDone;
        end else if (!zero_fill_q && (shift_cnt_q == 3'd7)) begin
          col_d   = col_q + 5'd1;
          req_d   = 1'b1;
          addr_d  = bg_map_addr(y_cur, scx_coarse_q, map_sel_q, col_q + 5'd1);
          state_d = StMapRd;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q      <= StIdle;
      line_q       <= '0;
      scy_q        <= '0;
      bgp_q        <= '0;
      lo_q         <= '0;
      scx_coarse_q <= '0;
      col_q        <= '0;
      map_sel_q    <= 1'b0;
      tile_sel_q   <= 1'b0;
      zero_fill_q  <= 1'b0;
      shift_cnt_q  <= '0;
      discard_q    <= '0;
      pix_cnt_q    <= '0;
      addr_q       <= '0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      scy_q        <= scy_d;
      bgp_q        <= bgp_d;
      lo_q         <= lo_d;
      scx_coarse_q <= scx_coarse_d;
      col_q        <= col_d;
      map_sel_q    <= map_sel_d;
      tile_sel_q   <= tile_sel_d;
      zero_fill_q  <= zero_fill_d;
      shift_cnt_q  <= shift_cnt_d;
      discard_q    <= discard_d;
      pix_cnt_q    <= pix_cnt_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign oMcuAddr        = addr_q;
  assign oMcuReadRequest = req_q;
  assign oBusy           = busy_q;
  assign oDone           = done_q;

  gpu_bg_pixel_shifter #(
    .PIXELS_PER_WORD(PIXELS_PER_WORD),
    .FB_ADDR_WIDTH  (FB_ADDR_WIDTH)
  ) u_shifter (
    .clk      (iClock),
    .reset    (iReset),
    .clear    (sh_clear),
    .load     (sh_load),
    .lo_plane (lo_q),
    .hi_plane (iMcuReadData),
    .shift    (sh_shift),
    .emit     (sh_emit),
    .zero_fill(zero_fill_q),
    .bgp      (bgp_q),
    .base_addr(fb_base),
    .fb_we    (oFramBufferWe),
    .fb_addr  (oFramBufferAddr),
    .fb_data  (oFramBufferData)
  );

endmodule

// File: tb/tb_gpu_bg_line_renderer.sv
// Scoreboard bench for gpu_bg_line_renderer: directed lines with hand-computed
// frame-buffer words; a VRAM responder with programmable latency serves reads.
module tb_gpu_bg_line_renderer;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start4 = 1'b0;
  logic [7:0]  line = 8'h00, lcdc = 8'h00, scx = 8'h00, scy = 8'h00, bgp = 8'h00;
  logic [15:0] mcu_addr;
  logic        mcu_req;
  logic [7:0]  mcu_data = 8'h00;
  logic        mcu_valid = 1'b0;
  logic        fb_we, busy, done;
  logic [15:0] fb_addr, fb_data;
  logic        fb4_we, busy4, done4, mcu4_req;
  logic [15:0] fb4_addr, mcu4_addr;
  logic [7:0]  fb4_data;

  logic [7:0]  vram [0:65535];
  wr_t         exp_q[$];
  wr_t         exp4_q[$];
  logic [15:0] reads[$];

  int compared = 0, mismatched = 0;
  int wr_cnt = 0, wr4_cnt = 0, done_cnt = 0, done4_cnt = 0;
  int lat = 0, stab_err = 0, wait_cnt = 0;
  logic        prev_req = 1'b0, was_valid;
  logic [15:0] prev_addr = 16'h0;

  always #5 clk = ~clk;

  gpu_bg_line_renderer #(.PIXELS_PER_WORD(8), .LINE_PIXELS(160), .FB_ADDR_WIDTH(16)) dut (
    .iClock(clk), .iReset(rst), .iStart(start), .iLine(line), .iLCDC(lcdc), .iSCX(scx),
    .iSCY(scy), .iBGP(bgp), .oMcuAddr(mcu_addr), .oMcuReadRequest(mcu_req),
    .iMcuReadData(mcu_data), .iMcuReadValid(mcu_valid), .oFramBufferWe(fb_we),
    .oFramBufferAddr(fb_addr), .oFramBufferData(fb_data), .oBusy(busy), .oDone(done)
  );

  gpu_bg_line_renderer #(.PIXELS_PER_WORD(4), .LINE_PIXELS(160), .FB_ADDR_WIDTH(16)) dut4 (
    .iClock(clk), .iReset(rst), .iStart(start4), .iLine(line), .iLCDC(lcdc), .iSCX(scx),
    .iSCY(scy), .iBGP(bgp), .oMcuAddr(mcu4_addr), .oMcuReadRequest(mcu4_req),
    .iMcuReadData(8'h00), .iMcuReadValid(1'b0), .oFramBufferWe(fb4_we),
    .oFramBufferAddr(fb4_addr), .oFramBufferData(fb4_data), .oBusy(busy4), .oDone(done4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // VRAM responder: valid after `lat` waiting cycles, one beat per request.
  initial begin : responder
    forever begin
      @(posedge clk);
      #1;
      was_valid = mcu_valid;
      if (prev_req && !was_valid && (!mcu_req || mcu_addr != prev_addr)) stab_err++;
      prev_req  = mcu_req;
      prev_addr = mcu_addr;
      if (mcu_valid) begin
        mcu_valid = 1'b0;
        wait_cnt  = 0;
      end
      if (mcu_req && !rst) begin
        if (wait_cnt >= lat) begin
          mcu_valid = 1'b1;
          mcu_data  = vram[mcu_addr];
          reads.push_back(mcu_addr);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every frame-buffer write.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (fb_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                   fb_addr, fb_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {16'h0, fb_addr}, {16'h0, e.addr});
          check("wr_data", {16'h0, fb_data}, {16'h0, e.data});
        end
      end
      if (fb4_we) begin
        wr4_cnt++;
        if (exp4_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write4: got addr 0x%0h data 0x%0h, expected none",
                   fb4_addr, fb4_data);
        end else begin
          e = exp4_q.pop_front();
          check("wr4_addr", {16'h0, fb4_addr}, {16'h0, e.addr});
          check("wr4_data", {24'h0, fb4_data}, {16'h0, e.data});
        end
      end
      if (done) done_cnt++;
      if (done4) done4_cnt++;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    for (int a = 16'h8000; a < 16'hA000; a++) vram[a] = 8'h00;
  endtask

  task automatic fill_map(input logic [7:0] v);
    for (int a = 16'h9800; a < 16'hA000; a++) vram[a] = v;
  endtask

  task automatic push_words(input int base, input int n, input logic [15:0] d);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = 16'(base + i);
      e.data = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_line(input logic [7:0] l_lcdc, input logic [7:0] l_scx,
                          input logic [7:0] l_scy, input logic [7:0] l_bgp,
                          input logic [7:0] l_line, input bit poke, input bit with4,
                          input string tag, output int cycles);
    int d0, w0;
    lcdc = l_lcdc; scx = l_scx; scy = l_scy; bgp = l_bgp; line = l_line;
    d0 = done_cnt;
    w0 = wr_cnt;
    reads.delete();
    @(posedge clk); #1;
    start  = 1'b1;
    start4 = with4;
    @(posedge clk); #1;
    start  = 1'b0;
    start4 = 1'b0;
    cycles = 1;
    check({tag, "_busy"}, {31'h0, busy}, 32'h1);
    while (!done && cycles < 3000) begin
      @(posedge clk); #1;
      cycles++;
      start = poke && (cycles == 40 || cycles == 150);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {31'h0, done}, 32'h1);
    check({tag, "_busy_low_at_done"}, {31'h0, busy}, 32'h0);
    if (with4) check({tag, "_done4_seen"}, {31'h0, done4}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_leftover_words"}, exp_q.size(), 32'd0);
    check({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
    check({tag, "_write_count"}, wr_cnt - w0, 32'd20);
  endtask

  task automatic setup_basic();
    clear_mem();
    fill_map(8'h01);
    vram[16'h8010] = 8'hFF;
    vram[16'h8011] = 8'h00;
  endtask

  initial begin : main
    int cyc, c, w4;
    for (int a = 0; a < 65536; a++) vram[a] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", {31'h0, mcu_req}, 32'h0);
    check("rst_mcu_addr", {16'h0, mcu_addr}, 32'h0);
    check("rst_we", {31'h0, fb_we}, 32'h0);
    check("rst_fb_addr", {16'h0, fb_addr}, 32'h0);
    check("rst_fb_data", {16'h0, fb_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    rst = 1'b0;

    // Basic line: colour 1 through BGP=E4 -> 01 per pixel.
    setup_basic();
    push_words(0, 20, 16'h5555);
    run_line(8'h91, 8'h00, 8'h00, 8'hE4, 8'd0, 1'b0, 1'b0, "basic", cyc);
    check("basic_reads", reads.size(), 32'd60);
    check("basic_rd0", {16'h0, reads[0]}, 32'h9800);
    check("basic_rd1", {16'h0, reads[1]}, 32'h8010);
    check("basic_rd2", {16'h0, reads[2]}, 32'h8011);

    // Signed tile addressing, line 3.
    clear_mem();
    fill_map(8'h01);
    vram[16'h9800] = 8'h80;
    vram[16'h9801] = 8'h00;
    vram[16'h8806] = 8'hF0;
    vram[16'h8807] = 8'hCC;
    vram[16'h9006] = 8'h00;
    vram[16'h9007] = 8'hFF;
    push_words(60, 1, 16'hF5A0);
    push_words(61, 1, 16'hAAAA);
    push_words(62, 18, 16'h0000);
    run_line(8'h81, 8'h00, 8'h00, 8'hE4, 8'd3, 1'b0, 1'b0, "signed", cyc);
    check("signed_rd1", {16'h0, reads[1]}, 32'h8806);
    check("signed_rd2", {16'h0, reads[2]}, 32'h8807);
    check("signed_rd4", {16'h0, reads[4]}, 32'h9006);

    // Fine X scroll with map wrap: SCX=FB.
    setup_basic();
    vram[16'h981F] = 8'h02;
    vram[16'h8020] = 8'h1B;
    push_words(0, 1, 16'h5155);
    push_words(1, 19, 16'h5555);
    run_line(8'h91, 8'hFB, 8'h00, 8'hE4, 8'd0, 1'b0, 1'b0, "finex", cyc);
    check("finex_reads", reads.size(), 32'd63);
    check("finex_rd0", {16'h0, reads[0]}, 32'h981F);
    check("finex_rd3", {16'h0, reads[3]}, 32'h9800);

    // SCY wrap (y=6) on the 9C00 map, palette 9C maps colour 3 -> 10.
    clear_mem();
    fill_map(8'h01);
    vram[16'h801C] = 8'hFF;
    vram[16'h801D] = 8'hFF;
    push_words(200, 20, 16'hAAAA);
    run_line(8'h99, 8'h00, 8'hFC, 8'h9C, 8'd10, 1'b0, 1'b0, "scy", cyc);
    check("scy_rd0", {16'h0, reads[0]}, 32'h9C00);
    check("scy_rd1", {16'h0, reads[1]}, 32'h801C);

    // Slow memory: same words as the basic line, request held stable.
    setup_basic();
    lat = 5;
    stab_err = 0;
    push_words(0, 20, 16'h5555);
    run_line(8'h91, 8'h00, 8'h00, 8'hE4, 8'd0, 1'b0, 1'b0, "slow", cyc);
    check("slow_reads", reads.size(), 32'd60);
    check("slow_req_stable", stab_err, 32'd0);
    lat = 0;

    // Background off: zero fill on both word widths; BGP=FF must not leak in.
    w4 = wr4_cnt;
    push_words(0, 20, 16'h0000);
    for (int i = 0; i < 40; i++) exp4_q.push_back('{addr: 16'(i), data: 16'h0000});
    run_line(8'h80, 8'h00, 8'h00, 8'hFF, 8'd0, 1'b0, 1'b1, "zero", cyc);
    check("zero_reads", reads.size(), 32'd0);
    check("zero_cycles", cyc, 32'd162);
    check("zero4_writes", wr4_cnt - w4, 32'd40);
    check("zero4_leftover", exp4_q.size(), 32'd0);

    // Reset mid-SHIFT: everything back to zero on the next edge.
    setup_basic();
    lcdc = 8'h91; scx = 8'h00; scy = 8'h00; bgp = 8'hE4; line = 8'd0;
    reads.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 0;
    while (reads.size() < 3 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check("midrst_reads_before", reads.size(), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_busy_before", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_req", {31'h0, mcu_req}, 32'h0);
    check("midrst_mcu_addr", {16'h0, mcu_addr}, 32'h0);
    check("midrst_we", {31'h0, fb_we}, 32'h0);
    check("midrst_fb_addr", {16'h0, fb_addr}, 32'h0);
    check("midrst_fb_data", {16'h0, fb_data}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Restart with start pulses while busy, which must be ignored.
    push_words(0, 20, 16'h5555);
    run_line(8'h91, 8'h00, 8'h00, 8'hE4, 8'd0, 1'b1, 1'b0, "restart", cyc);
    check("restart_reads", reads.size(), 32'd60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
